// File: rtl/sym_freq_hist.sv
// sym_freq_hist: per-symbol saturating frequency histogram, dumped as (symbol, count) pairs per block.
// Optional macro FREQ_SKIP_ZERO_EN suppresses zero-count entries from the dump.

module sym_freq_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);
    // An increment attempted at all-ones is the saturation event; the count holds.
    assign sat = inc && (cnt == '1);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)                   cnt <= '0;
        else if (clr)                 cnt <= '0;
        else if (inc && cnt != '1)    cnt <= cnt + 1'b1;
    end
endmodule

module sym_freq_hist #(
    parameter int SYM_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             sym_valid,
    input  logic [SYM_W-1:0] sym_data,
    input  logic             sym_last,
    output logic             sym_ready,
    output logic             out_valid,
    output logic [SYM_W-1:0] out_sym,
    output logic [CNT_W-1:0] out_count,
    output logic             out_last,
    input  logic             out_ready,
    output logic             sat_flag
);
    localparam int NUM_SYM = 2**SYM_W;

    typedef enum logic {COUNT = 1'b0, DUMP = 1'b1} state_t;

    state_t                          state;
    logic [SYM_W-1:0]                idx;
    logic [NUM_SYM-1:0][CNT_W-1:0]   cnt;
    logic [NUM_SYM-1:0]              sat_hit;
    logic                            in_dump, accept, hs, advance, dump_end, cnt_clr;

    assign in_dump   = (state == DUMP);
    assign accept    = !in_dump && sym_valid && !clear;
    assign hs        = out_valid && out_ready;
    assign cnt_clr   = clear || dump_end;
    assign sym_ready = !in_dump;
    assign out_sym   = idx;
    assign out_count = in_dump ? cnt[idx] : '0;

    genvar g;
    generate
        for (g = 0; g < NUM_SYM; g++) begin : g_cnt
            sym_freq_cnt #(.CNT_W(CNT_W)) u_cnt (
                .clk   (clk),
                .n_rst (n_rst),
                .clr   (cnt_clr),
                .inc   (accept && (sym_data == SYM_W'(g))),
                .cnt   (cnt[g]),
                .sat   (sat_hit[g])
            );
        end
    endgenerate

`ifdef FREQ_SKIP_ZERO_EN
    logic [NUM_SYM-1:0] nz;
    logic               more_nz;

    always_comb begin
        more_nz = 1'b0;
        for (int i = 0; i < NUM_SYM; i++) begin
            nz[i] = |cnt[i];
            if (nz[i] && i > int'(idx)) more_nz = 1'b1;
        end
    end

    // Zero entries are stepped over without a handshake; the scan also ends
    // cleanly at the top index if nothing valid remains.
    assign out_valid = in_dump && nz[idx];
    assign out_last  = out_valid && !more_nz;
    assign advance   = !out_valid || out_ready;
    assign dump_end  = in_dump && ((hs && out_last) ||
                                   (!out_valid && idx == SYM_W'(NUM_SYM-1)));
`else
    assign out_valid = in_dump;
    assign out_last  = in_dump && (idx == SYM_W'(NUM_SYM-1));
    assign advance   = hs;
    assign dump_end  = hs && out_last;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= COUNT;
            idx      <= '0;
            sat_flag <= 1'b0;
        end else if (clear || dump_end) begin
            state    <= COUNT;
            idx      <= '0;
            sat_flag <= 1'b0;
        end else begin
            if (|sat_hit) sat_flag <= 1'b1;
            if (in_dump) begin
                if (advance) idx <= idx + 1'b1;
            end else if (accept && sym_last) begin
                state <= DUMP;
                idx   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_sym_freq_hist.sv
// Self-checking bench for sym_freq_hist: histogram model plus directed and randomized blocks.
// Honors FREQ_SKIP_ZERO_EN the same way as the design.

module tb_sym_freq_hist;
    localparam int SYM_W   = 4;
    localparam int CNT_W   = 8;
    localparam int NUM_SYM = 16;
    localparam int CMAX    = 255;
`ifdef FREQ_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic             tb_clk = 1'b0;
    logic             n_rst = 1'b0;
    logic             clear = 1'b0;
    logic             sym_valid = 1'b0;
    logic [SYM_W-1:0] sym_data = '0;
    logic             sym_last = 1'b0;
    logic             sym_ready;
    logic             out_valid;
    logic [SYM_W-1:0] out_sym;
    logic [CNT_W-1:0] out_count;
    logic             out_last;
    logic             out_ready = 1'b0;
    logic             sat_flag;

    sym_freq_hist #(.SYM_W(SYM_W), .CNT_W(CNT_W)) dut (
        .clk(tb_clk), .n_rst(n_rst), .clear(clear),
        .sym_valid(sym_valid), .sym_data(sym_data), .sym_last(sym_last),
        .sym_ready(sym_ready), .out_valid(out_valid), .out_sym(out_sym),
        .out_count(out_count), .out_last(out_last), .out_ready(out_ready),
        .sat_flag(sat_flag)
    );

    always #5 tb_clk = ~tb_clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    // Model: raw occurrence counts of the current block, dump flag, and scan position.
    int hist [NUM_SYM];
    bit m_dump = 1'b0;
    bit m_sat  = 1'b0;
    int pos    = 0;

    function automatic int satc(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    function automatic int last_idx();
        int r = NUM_SYM - 1;
        if (SKIP) begin
            r = -1;
            for (int i = 0; i < NUM_SYM; i++) if (hist[i] != 0) r = i;
        end
        return r;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NUM_SYM; i++) hist[i] = 0;
        m_dump = 1'b0;
        m_sat  = 1'b0;
        pos    = 0;
    endfunction

    initial model_reset();

    always @(negedge tb_clk) begin
        bit e_valid;
        if (!n_rst) begin
            chk("rst_sym_ready", int'(sym_ready), 1);
            chk("rst_out_valid", int'(out_valid), 0);
            chk("rst_out_last",  int'(out_last), 0);
            chk("rst_out_sym",   int'(out_sym), 0);
            chk("rst_out_count", int'(out_count), 0);
            chk("rst_sat_flag",  int'(sat_flag), 0);
            model_reset();
        end else begin
            e_valid = m_dump && (!SKIP || hist[pos] != 0);
            chk("sym_ready", int'(sym_ready), int'(!m_dump));
            chk("out_valid", int'(out_valid), int'(e_valid));
            chk("sat_flag",  int'(sat_flag),  int'(m_sat));
            if (e_valid) begin
                chk("out_sym",   int'(out_sym),   pos);
                chk("out_count", int'(out_count), satc(hist[pos]));
                chk("out_last",  int'(out_last),  int'(pos == last_idx()));
            end
            if (clear) begin
                model_reset();
            end else if (m_dump) begin
                if (e_valid && out_ready) begin
                    if (pos == last_idx()) model_reset();
                    else pos++;
                end else if (!e_valid) begin
                    if (pos == NUM_SYM - 1) model_reset();
                    else pos++;
                end
            end else if (sym_valid) begin
                hist[sym_data]++;
                if (hist[sym_data] > CMAX) m_sat = 1'b1;
                if (sym_last) begin
                    m_dump = 1'b1;
                    pos    = 0;
                end
            end
        end
    end

    // Capture of what the DUT actually handed downstream, for literal checks.
    int cap_cnt [NUM_SYM];
    int cap_n    = 0;
    int cap_last = -1;

    task automatic cap_clear();
        for (int i = 0; i < NUM_SYM; i++) cap_cnt[i] = 0;
        cap_n    = 0;
        cap_last = -1;
    endtask

    always @(negedge tb_clk) begin
        if (n_rst && !clear && out_valid && out_ready) begin
            cap_cnt[out_sym] = int'(out_count);
            cap_n++;
            if (out_last) cap_last = int'(out_sym);
        end
    end

    function automatic int cap_sum_except(input int a, input int b, input int c);
        int s = 0;
        for (int i = 0; i < NUM_SYM; i++)
            if (i != a && i != b && i != c) s += cap_cnt[i];
        return s;
    endfunction

    task automatic cyc();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic send(input int s, input bit last);
        sym_valid = 1'b1;
        sym_data  = SYM_W'(s);
        sym_last  = last;
        cyc();
        sym_valid = 1'b0;
        sym_last  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (m_dump && n < 100) begin
            cyc();
            n++;
        end
        chk("drain_timeout", int'(m_dump), 0);
    endtask

    task automatic wait_idx(input int target, input string nm);
        int n = 0;
        while (!(!sym_ready && out_sym == SYM_W'(target)) && n < 40) begin
            cyc();
            n++;
        end
        chk(nm, int'(out_sym), target);
    endtask

    task automatic send_hist_block();
        send(3, 0); send(3, 0); send(5, 0); send(3, 0); send(0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        cap_clear();
        repeat (3) @(posedge tb_clk);
        #1 n_rst = 1'b1;
        @(negedge tb_clk);
        chk("post_rst_sym_ready", int'(sym_ready), 1);
        chk("post_rst_out_valid", int'(out_valid), 0);
        chk("post_rst_sat_flag",  int'(sat_flag), 0);
        @(posedge tb_clk);
        #1;

        // single symbol block
        cap_clear();
        send(0, 1);
        drain();
        chk("single_cnt0",   cap_cnt[0], 1);
        chk("single_others", cap_sum_except(0, 0, 0), 0);
        chk("single_pairs",  cap_n, SKIP ? 1 : 16);

        // histogram
        cap_clear();
        send_hist_block();
        drain();
        chk("hist_cnt0",   cap_cnt[0], 1);
        chk("hist_cnt3",   cap_cnt[3], 3);
        chk("hist_cnt5",   cap_cnt[5], 1);
        chk("hist_others", cap_sum_except(0, 3, 5), 0);
        chk("hist_last",   cap_last, SKIP ? 5 : 15);
        chk("hist_ready_back", int'(sym_ready), 1);

        // saturation
        cap_clear();
        for (int i = 0; i < 299; i++) send(7, 0);
        send(7, 1);
        chk("sat_set", int'(sat_flag), 1);
        drain();
        chk("sat_cnt7",  cap_cnt[7], 255);
        chk("sat_clear", int'(sat_flag), 0);

        // backpressure at idx 3, with a symbol poked during the dump
        cap_clear();
        send_hist_block();
        out_ready = 1'b1;
        wait_idx(3, "bp_reach3");
        out_ready = 1'b0;
        sym_valid = 1'b1;
        sym_data  = 4'd9;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("bp_sym",   int'(out_sym), 3);
            chk("bp_count", int'(out_count), 3);
            chk("bp_ready", int'(sym_ready), 0);
        end
        sym_valid = 1'b0;
        drain();
        chk("bp_cnt3",  cap_cnt[3], 3);
        chk("bp_cnt9",  cap_cnt[9], 0);
        chk("bp_pairs", cap_n, SKIP ? 3 : 16);

        // clear mid-dump at idx 6
        send(3, 0); send(3, 0); send(5, 0); send(9, 0); send(3, 0); send(0, 1);
        out_ready = 1'b1;
        wait_idx(6, "clr_reach6");
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk("clr_sym_ready", int'(sym_ready), 1);
        chk("clr_out_valid", int'(out_valid), 0);
        cap_clear();
        send(2, 1);
        drain();
        chk("clr_cnt2",   cap_cnt[2], 1);
        chk("clr_others", cap_sum_except(2, 2, 2), 0);

        // symbol + last + clear in one cycle is dropped
        sym_valid = 1'b1; sym_data = 4'd4; sym_last = 1'b1; clear = 1'b1;
        cyc();
        sym_valid = 1'b0; sym_last = 1'b0; clear = 1'b0;
        chk("simul_ready", int'(sym_ready), 1);
        cap_clear();
        send(11, 1);
        drain();
        chk("simul_cnt4",  cap_cnt[4], 0);
        chk("simul_cnt11", cap_cnt[11], 1);

        // randomized blocks with backpressure, stray symbols, clear and reset mid-dump
        for (int b = 0; b < 30; b++) begin
            int len;
            int n;
            int hi;
            len = $urandom_range(1, 40);
            hi  = (b % 3 == 0) ? 3 : NUM_SYM - 1;
            for (int k = 0; k < len; k++) begin
                while ($urandom_range(0, 3) == 0) cyc();
                send($urandom_range(0, hi), k == len - 1);
            end
            n = 0;
            while (m_dump && n < 300) begin
                out_ready = ($urandom_range(0, 3) != 0);
                sym_valid = $urandom_range(0, 1);
                sym_data  = SYM_W'($urandom_range(0, NUM_SYM - 1));
                if (b == 10 && n == 5) clear = 1'b1;
                if (b == 20 && n == 4) n_rst = 1'b0;
                cyc();
                clear = 1'b0;
                n_rst = 1'b1;
                n++;
            end
            sym_valid = 1'b0;
            chk("rand_dump_timeout", int'(m_dump), 0);
        end

        out_ready = 1'b0;
        cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sym_freq_hist.md
# sym_freq_hist

Symbol-frequency histogram stage at the front of the Huffman encoder. It accepts a stream of fixed-width symbols and keeps one saturating occurrence counter per symbol value. When the final symbol of a block arrives, it drains the table as (symbol, count) pairs over a valid/ready handshake to the tree-build stage, then re-arms for the next block. Its per-symbol counters have the same clear / enable / saturate behaviour as the encoder's accumulating counter, replicated across the alphabet.

## Interface
Parameters:
- SYM_W, 4: symbol width in bits; alphabet size NUM_SYM = 2**SYM_W.
- CNT_W, 8: width of each frequency counter.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush: zero all counters, drop any dump, return to COUNT.
- sym_valid  in  1  input symbol present.
- sym_data  in  SYM_W  input symbol value.
- sym_last  in  1  final symbol of block, qualified by sym_valid.
- sym_ready  out  1  stage accepts a symbol.
- out_valid  out  1  (symbol, count) pair valid.
- out_sym  out  SYM_W  symbol index of the current pair.
- out_count  out  CNT_W  frequency of out_sym.
- out_last  out  1  final pair of the dump, qualified by out_valid.
- out_ready  in  1  downstream accepts the pair.
- sat_flag  out  1  sticky flag: a counter saturated during the current block.

## Operation
- The FSM has two states: COUNT and DUMP. Reset state is COUNT.
- COUNT state:
  - sym_ready = 1 and out_valid = 0.
  - On sym_valid, cnt[sym_data] increments by 1. At all-ones it holds and sets sat_flag.
  - If sym_last is also high, the increment still applies, the FSM moves to DUMP, and idx is set to 0.
- DUMP state:
  - sym_ready = 0. Input symbols are not accepted.
  - out_sym = idx and out_count = cnt[idx], driven combinationally from the registers.
  - out_valid = 1 for every idx (without skip mode; see Configuration).
  - out_last = 1 when idx is the final emitted entry.
  - When out_valid && out_ready, idx advances by 1.
  - Handshaking the out_last pair zeroes every counter, clears sat_flag, and returns the FSM to COUNT.
- Backpressure: while out_valid && !out_ready, out_sym, out_count and out_last hold stable.
- clear has priority over every other input in both states:
  - the next cycle is COUNT with all counters 0, idx 0 and sat_flag 0;
  - a symbol presented in the same cycle as clear is discarded.
- Counter arithmetic is unsigned. Counters saturate and never wrap.
- Reset values: FSM = COUNT, all counters = 0, idx = 0, sat_flag = 0.
- Output values during reset:
  - sym_ready = 1;
  - out_valid = 0, out_last = 0;
  - out_sym = 0, out_count = 0.

## Timing
- Counter updates are registered. A count is visible one cycle after the symbol is accepted.
- The sym_last accept at edge N makes the FSM DUMP after N. The first pair is presented in the cycle after edge N and already includes the last symbol.
- Throughput:
  - COUNT: one symbol per cycle.
  - DUMP: one pair per cycle when out_ready is held high.
- A full dump takes NUM_SYM cycles without skip mode. sym_ready returns to 1 in the cycle after the out_last handshake.
- Asserting n_rst mid-dump aborts the dump immediately (asynchronous). No partial state survives.

## Configuration
- FREQ_SKIP_ZERO_EN undefined:
  - every index 0..NUM_SYM-1 is emitted, including zero counts;
  - out_last is asserted at idx = NUM_SYM-1.
- FREQ_SKIP_ZERO_EN defined, zero-count entries are suppressed:
  - out_valid = 0 while cnt[idx] = 0, and idx advances one per cycle regardless of out_ready;
  - out_last is asserted on the highest nonzero index, computed from a nonzero mask of indices above idx;
  - a dump of k nonzero symbols ends at the handshake of the highest nonzero index.

## Test plan
- Reset: hold n_rst = 0, then release.
  - Required: sym_ready = 1, out_valid = 0, sat_flag = 0.
  - Then send a single sym 0 with sym_last: the dump shows cnt[0] = 1 and all other counts 0.
- Histogram: send symbols 3,3,5,3,0 with sym_last on the 0, out_ready = 1.
  - Required pairs: (0,1), (3,3), (5,1), all others 0.
  - out_last: on symbol 15 without the macro, on symbol 5 with FREQ_SKIP_ZERO_EN.
- Saturation: CNT_W = 8, send 300 copies of symbol 7, the last with sym_last.
  - Required: out_count = 255 for symbol 7, sat_flag = 1.
  - sat_flag = 0 after the out_last handshake.
- Backpressure: during the dump hold out_ready = 0 for 4 cycles at idx 3.
  - Required: out_sym = 3 and its count are held stable.
  - Required: no pair is lost or duplicated, and no symbol is accepted.
- Clear mid-dump: assert clear at idx 6.
  - Required next cycle: COUNT, sym_ready = 1, all counters 0.
  - A following block of symbol 2 with sym_last dumps only (2,1).
- Simultaneous events:
  - sym_valid + sym_last + clear in the same cycle: the symbol is dropped and the FSM stays in COUNT.
  - A symbol presented during DUMP: it is not counted (sym_ready = 0).
